traffic_light_controller: RTL and testbench

Sequencer for a two-way intersection: north-south main street and east-west side street. Steps both signal heads through green, yellow and all-red phases on a 1 Hz tick strobe. Serves the side street only on sensor demand. Switches to a night flashing mode when the upstream time-of-day stage drives `dayIn` low.

---
 rtl/traffic_light_controller_pkg.sv | 18 +
 rtl/traffic_light_controller_phase_timer.sv | 38 +++
 rtl/traffic_light_controller.sv | 137 +++++++++++++
 tb/tb_traffic_light_controller.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_controller_pkg.sv
// Shared codes for the intersection sequencer.
// State encodings and signal-head light patterns.
package traffic_light_controller_pkg;

  localparam logic [2:0] S_NS_GREEN  = 3'd0;
  localparam logic [2:0] S_NS_YELLOW = 3'd1;
  localparam logic [2:0] S_ALL_RED1  = 3'd2;
  localparam logic [2:0] S_EW_GREEN  = 3'd3;
  localparam logic [2:0] S_EW_YELLOW = 3'd4;
  localparam logic [2:0] S_ALL_RED2  = 3'd5;
  localparam logic [2:0] S_NIGHT     = 3'd6;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

endpackage

// File: rtl/traffic_light_controller_phase_timer.sv
// Phase timer: 8-bit loadable down-counter.
// Expires on a tick while at zero; parks at zero.
module phase_timer #(
  parameter logic [7:0] RST_VAL = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       loadIn,
  input  logic [7:0] loadValIn,
  input  logic       tickIn,
  output logic       expireOut
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Load wins over counting; count stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (loadIn) begin
      cnt_d = loadValIn;
    end else if (tickIn && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expireOut = tickIn && (cnt_q == 8'd0);

endmodule

// File: rtl/traffic_light_controller.sv
// Two-way intersection sequencer with demand-served
// side street and night flashing mode.
module traffic_light_controller #(
  parameter int unsigned GREEN_T  = 20,
  parameter int unsigned YELLOW_T = 4,
  parameter int unsigned ALLRED_T = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tickIn,
  input  logic       dayIn,
  input  logic       sideCarIn,
  output logic [2:0] nsLightOut,
  output logic [2:0] ewLightOut,
  output logic [2:0] phaseOut
);

  import traffic_light_controller_pkg::*;

  localparam logic [7:0] GREEN_V  = 8'(GREEN_T - 1);
  localparam logic [7:0] YELLOW_V = 8'(YELLOW_T - 1);
  localparam logic [7:0] ALLRED_V = 8'(ALLRED_T - 1);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       car_pending_q;
  logic       car_pending_d;
  logic       blink_q;
  logic       blink_d;
  logic       expire;
  logic       load;
  logic [7:0] load_val;

  phase_timer #(
    .RST_VAL (ALLRED_V)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .loadIn    (load),
    .loadValIn (load_val),
    .tickIn    (tickIn),
    .expireOut (expire)
  );

  // Next-state logic; unused code 7 falls back to clearance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_NS_GREEN: begin
        if (expire && (car_pending_q || !dayIn))
          state_d = S_NS_YELLOW;
      end
      S_NS_YELLOW: begin
        if (expire) state_d = S_ALL_RED1;
      end
      S_ALL_RED1: begin
        if (expire)
          state_d = dayIn ? S_EW_GREEN : S_NIGHT;
      end
      S_EW_GREEN: begin
        if (expire) state_d = S_EW_YELLOW;
      end
      S_EW_YELLOW: begin
        if (expire) state_d = S_ALL_RED2;
      end
      S_ALL_RED2: begin
        if (expire)
          state_d = dayIn ? S_NS_GREEN : S_NIGHT;
      end
      S_NIGHT: begin
        if (dayIn) state_d = S_ALL_RED2;
      end
      default: state_d = S_ALL_RED2;
    endcase
  end

  // Reload the timer with the new phase length on every change.
  always_comb begin
    load = (state_d != state_q);
    case (state_d)
      S_NS_GREEN, S_EW_GREEN:   load_val = GREEN_V;
      S_NS_YELLOW, S_EW_YELLOW: load_val = YELLOW_V;
      default:                  load_val = ALLRED_V;
    endcase
  end

  // Side demand latch; EW_GREEN entry clear beats a new request.
  always_comb begin
    car_pending_d = car_pending_q;
    if ((state_d == S_EW_GREEN) && (state_q != S_EW_GREEN))
      car_pending_d = 1'b0;
    else if (sideCarIn && (state_q != S_EW_GREEN))
      car_pending_d = 1'b1;
  end

  // Flash phase: starts lit, toggles per tick.
  always_comb begin
    blink_d = blink_q;
    if ((state_d == S_NIGHT) && (state_q != S_NIGHT))
      blink_d = 1'b1;
    else if ((state_q == S_NIGHT) && tickIn)
      blink_d = ~blink_q;
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_ALL_RED2;
      car_pending_q <= 1'b0;
      blink_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      car_pending_q <= car_pending_d;
      blink_q       <= blink_d;
    end
  end

  // Moore light decode.
  always_comb begin
    nsLightOut = RED;
    ewLightOut = RED;
    case (state_q)
      S_NS_GREEN:  nsLightOut = GRN;
      S_NS_YELLOW: nsLightOut = YEL;
      S_EW_GREEN:  ewLightOut = GRN;
      S_EW_YELLOW: ewLightOut = YEL;
      S_NIGHT: begin
        nsLightOut = blink_q ? YEL : OFF;
        ewLightOut = blink_q ? RED : OFF;
      end
      default: ;
    endcase
  end

  assign phaseOut = state_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: scenario tasks
// plus a random soak against a phase-level model.
module tb_traffic_light_controller;

  localparam int GT = 3;
  localparam int YT = 2;
  localparam int AT = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tickIn = 1'b0;
  logic       dayIn = 1'b1;
  logic       sideCarIn = 1'b0;
  logic [2:0] nsLightOut;
  logic [2:0] ewLightOut;
  logic [2:0] phaseOut;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;

  // Model: phase id, ticks remaining (>=1), demand, blink.
  int m_st = 5;
  int m_left = AT;
  bit m_pend = 0;
  bit m_blink = 1;

  traffic_light_controller #(
    .GREEN_T  (GT),
    .YELLOW_T (YT),
    .ALLRED_T (AT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tickIn     (tickIn),
    .dayIn      (dayIn),
    .sideCarIn  (sideCarIn),
    .nsLightOut (nsLightOut),
    .ewLightOut (ewLightOut),
    .phaseOut   (phaseOut)
  );

  always #5 clk = ~clk;

  function automatic int dur(int s);
    case (s)
      0, 3:    return GT;
      1, 4:    return YT;
      default: return AT;
    endcase
  endfunction

  function automatic logic [2:0] exp_ns();
    case (m_st)
      0:       return 3'b001;
      1:       return 3'b010;
      6:       return m_blink ? 3'b010 : 3'b000;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_ew();
    case (m_st)
      3:       return 3'b001;
      4:       return 3'b010;
      6:       return m_blink ? 3'b100 : 3'b000;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [8:0] exp_all();
    return {exp_ns(), exp_ew(), 3'(m_st)};
  endfunction

  task automatic model_step(bit r, bit t, bit d, bit car);
    bit ex;
    int nx;
    if (r) begin
      m_st = 5; m_left = AT; m_pend = 0; m_blink = 1;
      return;
    end
    ex = t && (m_left == 1);
    nx = m_st;
    case (m_st)
      0: if (ex && (m_pend || !d)) nx = 1;
      1: if (ex) nx = 2;
      2: if (ex) nx = d ? 3 : 6;
      3: if (ex) nx = 4;
      4: if (ex) nx = 5;
      5: if (ex) nx = d ? 0 : 6;
      6: if (d) nx = 5;
      default: nx = 5;
    endcase
    if (nx == 3 && m_st != 3) m_pend = 0;
    else if (car && m_st != 3) m_pend = 1;
    if (nx != m_st) begin
      m_left = dur(nx);
      if (nx == 6) m_blink = 1;
    end else begin
      if (t && m_left > 1) m_left--;
      if (m_st == 6 && t) m_blink = !m_blink;
    end
    m_st = nx;
  endtask

  // One clock: tick every 4th cycle, sample at negedge.
  task automatic cycle();
    tickIn = (tick_cnt % 4 == 3);
    tick_cnt++;
    @(posedge clk);
    model_step(rst, tickIn, dayIn, sideCarIn);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1; dayIn = 1; sideCarIn = 0;
    cycle(); cycle();
    rst = 0;
    checks++;
    if ({nsLightOut, ewLightOut, phaseOut} !== 9'b100_100_101) begin
      errors++;
      $display("FAIL reset_out got %b/%b/%0d want 100/100/5",
               nsLightOut, ewLightOut, phaseOut);
    end
    checks++;
    if (dut.car_pending_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_pend got %b want 0", dut.car_pending_q);
    end
    ok = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if ({nsLightOut, ewLightOut, phaseOut} !== exp_all()) begin
        errors++;
        $display("FAIL reset_model got %b want %b",
                 {nsLightOut, ewLightOut, phaseOut}, exp_all());
      end
      if (phaseOut == 3'd0) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_to_green got %0d want 0 within 1 tick", phaseOut);
    end
    for (int i = 0; i < 80; i++) begin
      cycle();
      checks++;
      if ({nsLightOut, ewLightOut, phaseOut} !== 9'b001_100_000) begin
        errors++;
        $display("FAIL idle_hold got %b/%b/%0d want 001/100/0",
                 nsLightOut, ewLightOut, phaseOut);
      end
    end
  endtask

  task automatic test_side_request();
    int len [8];
    bit ok, seen3;
    foreach (len[i]) len[i] = 0;
    sideCarIn = 1;
    cycle();
    sideCarIn = 0;
    checks++;
    if (dut.car_pending_q !== 1'b1) begin
      errors++;
      $display("FAIL side_pend_set got %b want 1", dut.car_pending_q);
    end
    ok = 0; seen3 = 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      checks++;
      if ({nsLightOut, ewLightOut, phaseOut} !== exp_all()) begin
        errors++;
        $display("FAIL side_model got %b want %b",
                 {nsLightOut, ewLightOut, phaseOut}, exp_all());
      end
      if (phaseOut == 3'd3 && !seen3) begin
        seen3 = 1;
        checks++;
        if (dut.car_pending_q !== 1'b0) begin
          errors++;
          $display("FAIL side_pend_clr got %b want 0", dut.car_pending_q);
        end
      end
      if (phaseOut == 3'd0 && len[5] > 0) begin ok = 1; break; end
      len[phaseOut]++;
    end
    checks++;
    if (!ok || len[1] != 4*YT || len[2] != 4*AT || len[3] != 4*GT ||
        len[4] != 4*YT || len[5] != 4*AT) begin
      errors++;
      $display("FAIL side_lengths got %0d %0d %0d %0d %0d want %0d %0d %0d %0d %0d",
               len[1], len[2], len[3], len[4], len[5],
               4*YT, 4*AT, 4*GT, 4*YT, 4*AT);
    end
  endtask

  task automatic test_night_entry();
    int len [8];
    bit ok;
    int k;
    foreach (len[i]) len[i] = 0;
    sideCarIn = 1;
    cycle();
    sideCarIn = 0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (phaseOut == 3'd1) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL night_reach_yel got %0d want 1", phaseOut);
    end
    len[1] = 1;
    dayIn = 0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      checks++;
      if ({nsLightOut, ewLightOut, phaseOut} !== exp_all()) begin
        errors++;
        $display("FAIL night_model got %b want %b",
                 {nsLightOut, ewLightOut, phaseOut}, exp_all());
      end
      if (phaseOut == 3'd6) begin ok = 1; break; end
      len[phaseOut]++;
    end
    checks++;
    if (!ok || len[1] != 4*YT || len[2] != 4*AT) begin
      errors++;
      $display("FAIL night_entry_len got ok=%0d y=%0d r=%0d want 1 %0d %0d",
               ok, len[1], len[2], 4*YT, 4*AT);
    end
    k = 0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ((k % 2 == 0 && {nsLightOut, ewLightOut} !== 6'b010_100) ||
          (k % 2 == 1 && {nsLightOut, ewLightOut} !== 6'b000_000)) begin
        errors++;
        $display("FAIL flash got %b/%b at tick %0d", nsLightOut, ewLightOut, k);
      end
      cycle();
      if (tickIn) k++;
    end
  endtask

  task automatic test_night_exit();
    bit ok;
    dayIn = 1;
    cycle();
    checks++;
    if ({nsLightOut, ewLightOut, phaseOut} !== 9'b100_100_101) begin
      errors++;
      $display("FAIL exit_clear got %b/%b/%0d want 100/100/5",
               nsLightOut, ewLightOut, phaseOut);
    end
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if ({nsLightOut, ewLightOut, phaseOut} !== exp_all()) begin
        errors++;
        $display("FAIL exit_model got %b want %b",
                 {nsLightOut, ewLightOut, phaseOut}, exp_all());
      end
      if (phaseOut == 3'd0) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL exit_green got %0d want 0", phaseOut);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    sideCarIn = 1;
    cycle();
    sideCarIn = 0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (phaseOut == 3'd3) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_reach_ew got %0d want 3", phaseOut);
    end
    while (tick_cnt % 4 != 3) cycle();
    rst = 1; sideCarIn = 1;
    cycle();
    rst = 0; sideCarIn = 0;
    checks++;
    if ({nsLightOut, ewLightOut, phaseOut} !== 9'b100_100_101) begin
      errors++;
      $display("FAIL mid_reset got %b/%b/%0d want 100/100/5",
               nsLightOut, ewLightOut, phaseOut);
    end
    checks++;
    if (dut.car_pending_q !== 1'b0) begin
      errors++;
      $display("FAIL mid_pend got %b want 0", dut.car_pending_q);
    end
  endtask

  task automatic test_soak();
    bit nsg, ewg;
    for (int i = 0; i < 40000; i++) begin
      sideCarIn = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 399) == 0) dayIn = !dayIn;
      cycle();
      nsg = nsLightOut[1] | nsLightOut[0];
      ewg = ewLightOut[1] | ewLightOut[0];
      checks++;
      if (nsg && ewg) begin
        errors++;
        $display("FAIL soak_conflict got %b/%b", nsLightOut, ewLightOut);
      end
      checks++;
      if (phaseOut === 3'd7) begin
        errors++;
        $display("FAIL soak_phase got 7 want <7");
      end
      checks++;
      if ({nsLightOut, ewLightOut, phaseOut} !== exp_all()) begin
        errors++;
        $display("FAIL soak_model cyc %0d got %b want %b",
                 i, {nsLightOut, ewLightOut, phaseOut}, exp_all());
      end
    end
    sideCarIn = 0;
  endtask

  initial begin
    test_reset();
    test_side_request();
    test_night_entry();
    test_night_exit();
    test_reset_mid();
    test_soak();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
